// File: rtl/ide_taskfile_if.sv
// CPU-side and HPS-side access signals of the IDE task file and sector buffer.
interface ide_taskfile_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              cpu_sel;
    logic              cpu_we;
    logic [2:0]        cpu_addr;
    logic [15:0]       cpu_din;
    logic [15:0]       cpu_dout;
    logic              cpu_irq;
    logic              ide_req;
    logic              ide_ack;
    logic              ide_err;
    logic [2:0]        ide_reg_i_adr;
    logic [7:0]        ide_reg_i;
    logic              ide_reg_we;
    logic [2:0]        ide_reg_o_adr;
    logic [7:0]        ide_reg_o;
    logic [ADDR_W-1:0] ide_data_addr;
    logic [15:0]       ide_data_o;
    logic [15:0]       ide_data_i;
    logic              ide_data_rd;
    logic              ide_data_we;

    // Bus driver side (CPU decode + HPS)
    modport master (
        output cpu_sel, cpu_we, cpu_addr, cpu_din,
        output ide_ack, ide_err, ide_reg_i_adr, ide_reg_we, ide_reg_o_adr, ide_reg_o,
        output ide_data_addr, ide_data_o, ide_data_rd, ide_data_we,
        input  cpu_dout, cpu_irq, ide_req, ide_reg_i, ide_data_i
    );

    // Task-file block side
    modport slave (
        input  cpu_sel, cpu_we, cpu_addr, cpu_din,
        input  ide_ack, ide_err, ide_reg_i_adr, ide_reg_we, ide_reg_o_adr, ide_reg_o,
        input  ide_data_addr, ide_data_o, ide_data_rd, ide_data_we,
        output cpu_dout, cpu_irq, ide_req, ide_reg_i, ide_data_i
    );
endinterface

// File: rtl/ide_taskfile.sv
// ATA task file plus one-sector buffer shared between the CPU and the HPS.
module ide_taskfile #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clk_sys,
    input  logic        reset,
    ide_taskfile_if.slave bus
);
    localparam int unsigned SECTOR_WORDS = 2**ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRQ_IN, S_DRQ_OUT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [7:0]        r_tf [1:6];
    logic [7:0]        r_cmd;
    logic              r_wtype;
    logic              r_err;
    logic              r_irq;
    logic              r_req;
    logic [15:0]       r_dout;
    logic [15:0]       r_data_i;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_hcnt;
    logic [15:0]       r_buf [SECTOR_WORDS];

    logic              w_cpu_rd;
    logic              w_cpu_wr;
    logic              w_cmd_wr;
    logic              w_new_wtype;
    logic              w_cpu_d_rd;
    logic              w_cpu_d_wr;
    logic              w_hps_buf_wr;
    logic              w_hps_buf_rd;
    logic              w_ptr_last;
    logic              w_hcnt_last;
    logic [7:0]        w_cnt_dec_val;
    logic              w_bsy;
    logic              w_drq;
    logic [7:0]        w_status;
    logic [15:0]       w_cpu_rd_val;
    logic [7:0]        w_reg_i;

    logic              w_req_set;
    logic              w_irq_set;
    logic              w_err_load;
    logic              w_cnt_dec;
    logic              w_ctr_clr;

    // Access qualifiers and counter-wrap detection
    assign w_cpu_rd      = bus.cpu_sel & ~bus.cpu_we;
    assign w_cpu_wr      = bus.cpu_sel &  bus.cpu_we;
    assign w_cmd_wr      = w_cpu_wr && (bus.cpu_addr == 3'd7) && (r_state == S_IDLE);
    assign w_new_wtype   = (bus.cpu_din[7:1] == 7'h18);
    assign w_cpu_d_rd    = w_cpu_rd && (bus.cpu_addr == 3'd0) && (r_state == S_DRQ_IN);
    assign w_cpu_d_wr    = w_cpu_wr && (bus.cpu_addr == 3'd0) && (r_state == S_DRQ_OUT);
    assign w_hps_buf_wr  = bus.ide_data_we && (r_state == S_BUSY) && !r_wtype;
    assign w_hps_buf_rd  = bus.ide_data_rd && (r_state == S_BUSY) &&  r_wtype;
    assign w_ptr_last    = &r_ptr;
    assign w_hcnt_last   = &r_hcnt;
    assign w_cnt_dec_val = r_tf[2] - 8'd1;

    assign w_bsy    = (r_state == S_BUSY);
    assign w_drq    = (r_state == S_DRQ_IN) || (r_state == S_DRQ_OUT);
    assign w_status = {w_bsy, ~w_bsy, 1'b0, ~w_bsy, w_drq, 2'b00, r_err};

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; ide_ack wins over a same-cycle counter wrap
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_wr) w_state_nxt = w_new_wtype ? S_DRQ_OUT : S_BUSY;
            end
            S_BUSY: begin
                if (bus.ide_ack)
                    w_state_nxt = (r_wtype && (r_tf[2] != 8'd1) && !bus.ide_err) ? S_DRQ_OUT : S_IDLE;
                else if (w_hps_buf_wr && w_hcnt_last)
                    w_state_nxt = S_DRQ_IN;
            end
            S_DRQ_IN: begin
                if (w_cpu_d_rd && w_ptr_last)
                    w_state_nxt = (w_cnt_dec_val != 8'd0) ? S_BUSY : S_IDLE;
            end
            S_DRQ_OUT: begin
                if (w_cpu_d_wr && w_ptr_last) w_state_nxt = S_BUSY;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-state control strobes feeding the datapath registers
    always_comb begin
        w_req_set  = 1'b0;
        w_irq_set  = 1'b0;
        w_err_load = 1'b0;
        w_cnt_dec  = 1'b0;
        w_ctr_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ctr_clr = w_cmd_wr;
                w_req_set = w_cmd_wr && !w_new_wtype;
            end
            S_BUSY: begin
                if (bus.ide_ack) begin
                    w_irq_set  = 1'b1;
                    w_err_load = 1'b1;
                    w_ctr_clr  = 1'b1;
                    w_cnt_dec  = r_wtype && (r_tf[2] != 8'd1) && !bus.ide_err;
                end else if (w_hps_buf_wr && w_hcnt_last) begin
                    w_irq_set = 1'b1;
                end
            end
            S_DRQ_IN: begin
                if (w_cpu_d_rd && w_ptr_last) begin
                    w_cnt_dec = 1'b1;
                    w_req_set = (w_cnt_dec_val != 8'd0);
                end
            end
            S_DRQ_OUT: begin
                w_req_set = w_cpu_d_wr && w_ptr_last;
            end
            default: ;
        endcase
    end

    // CPU read data selection
    always_comb begin
        w_cpu_rd_val = 16'h0000;
        case (bus.cpu_addr)
            3'd0:    w_cpu_rd_val = (r_state == S_DRQ_IN) ? r_buf[r_ptr] : 16'hFFFF;
            3'd1:    w_cpu_rd_val = {8'h00, r_tf[1]};
            3'd2:    w_cpu_rd_val = {8'h00, r_tf[2]};
            3'd3:    w_cpu_rd_val = {8'h00, r_tf[3]};
            3'd4:    w_cpu_rd_val = {8'h00, r_tf[4]};
            3'd5:    w_cpu_rd_val = {8'h00, r_tf[5]};
            3'd6:    w_cpu_rd_val = {8'h00, r_tf[6]};
            default: w_cpu_rd_val = {8'h00, w_status};
        endcase
    end

    // HPS task-file read port
    always_comb begin
        w_reg_i = 8'h00;
        case (bus.ide_reg_i_adr)
            3'd1:    w_reg_i = r_tf[1];
            3'd2:    w_reg_i = r_tf[2];
            3'd3:    w_reg_i = r_tf[3];
            3'd4:    w_reg_i = r_tf[4];
            3'd5:    w_reg_i = r_tf[5];
            3'd6:    w_reg_i = r_tf[6];
            3'd7:    w_reg_i = r_cmd;
            default: w_reg_i = 8'h00;
        endcase
    end

    // Task-file, status and pointer registers; HPS writes beat CPU writes
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int k = 1; k <= 6; k++) r_tf[k] <= 8'h00;
            r_cmd    <= 8'h00;
            r_wtype  <= 1'b0;
            r_err    <= 1'b0;
            r_irq    <= 1'b0;
            r_req    <= 1'b0;
            r_dout   <= 16'h0000;
            r_data_i <= 16'h0000;
            r_ptr    <= '0;
            r_hcnt   <= '0;
        end else begin
            for (int k = 1; k <= 6; k++) begin
                if (bus.ide_reg_we && (bus.ide_reg_o_adr == 3'(k)))
                    r_tf[k] <= bus.ide_reg_o;
                else if (w_cpu_wr && (r_state == S_IDLE) && (bus.cpu_addr == 3'(k)))
                    r_tf[k] <= bus.cpu_din[7:0];
                else if ((k == 2) && w_cnt_dec)
                    r_tf[k] <= w_cnt_dec_val;
            end

            if (w_cmd_wr) begin
                r_cmd   <= bus.cpu_din[7:0];
                r_wtype <= w_new_wtype;
            end

            if (w_cmd_wr)        r_err <= 1'b0;
            else if (w_err_load) r_err <= bus.ide_err;

            if (w_irq_set)
                r_irq <= 1'b1;
            else if (w_cmd_wr || (w_cpu_rd && (bus.cpu_addr == 3'd7)))
                r_irq <= 1'b0;

            r_req <= w_req_set;

            if (w_cpu_rd) r_dout <= w_cpu_rd_val;

            r_data_i <= r_buf[bus.ide_data_addr];

            if (w_ctr_clr)                     r_ptr <= '0;
            else if (w_cpu_d_rd || w_cpu_d_wr) r_ptr <= r_ptr + ADDR_W'(1);

            if (w_ctr_clr)                         r_hcnt <= '0;
            else if (w_hps_buf_wr || w_hps_buf_rd) r_hcnt <= r_hcnt + ADDR_W'(1);
        end
    end

    // Sector buffer storage
    always_ff @(posedge clk_sys) begin
        if (w_hps_buf_wr)
            r_buf[bus.ide_data_addr] <= bus.ide_data_o;
        else if (w_cpu_d_wr)
            r_buf[r_ptr] <= bus.cpu_din;
    end

    assign bus.cpu_dout   = r_dout;
    assign bus.cpu_irq    = r_irq;
    assign bus.ide_req    = r_req;
    assign bus.ide_reg_i  = w_reg_i;
    assign bus.ide_data_i = r_data_i;
endmodule

// File: tb/tb_ide_taskfile.sv
// Scoreboard bench for the IDE task file: reads, sector transfers, errors and reset.
module tb_ide_taskfile;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errs;
    int   req_cnt;

    logic [15:0] sb_q[$];
    string       tag_q[$];

    ide_taskfile_if #(.ADDR_W(8)) bus ();

    ide_taskfile #(.ADDR_W(8)) dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count ide_req cycles seen by the HPS
    always @(posedge clk) begin
        if (!rst && bus.ide_req) req_cnt <= req_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [15:0] e, input string tg);
        sb_q.push_back(e);
        tag_q.push_back(tg);
    endtask

    task automatic sb_pop_check(input logic [15:0] obs);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'(obs), 32'hDEAD_BEEF);
        end else begin
            logic [15:0] e;
            string       tg;
            e  = sb_q.pop_front();
            tg = tag_q.pop_front();
            chk(tg, 32'(obs), 32'(e));
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge
    task automatic cpu_rd(input logic [2:0] a, input logic [15:0] e, input string tg);
        sb_push(e, tg);
        bus.cpu_sel = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
        @(posedge clk); #1;
        bus.cpu_sel = 1'b0;
        sb_pop_check(bus.cpu_dout);
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [15:0] d);
        bus.cpu_sel = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_din = d;
        @(posedge clk); #1;
        bus.cpu_sel = 1'b0; bus.cpu_we = 1'b0;
    endtask

    task automatic hps_wr(input logic [7:0] a, input logic [15:0] d);
        bus.ide_data_we = 1'b1; bus.ide_data_addr = a; bus.ide_data_o = d;
        @(posedge clk); #1;
        bus.ide_data_we = 1'b0;
    endtask

    task automatic hps_rd(input logic [7:0] a, input logic [15:0] e, input string tg);
        sb_push(e, tg);
        bus.ide_data_rd = 1'b1; bus.ide_data_addr = a;
        @(posedge clk); #1;
        bus.ide_data_rd = 1'b0;
        sb_pop_check(bus.ide_data_i);
    endtask

    task automatic hps_reg(input logic [2:0] a, input logic [7:0] e, input string tg);
        bus.ide_reg_i_adr = a;
        #1;
        chk(tg, 32'(bus.ide_reg_i), 32'(e));
    endtask

    task automatic ack(input logic err);
        bus.ide_ack = 1'b1; bus.ide_err = err;
        @(posedge clk); #1;
        bus.ide_ack = 1'b0; bus.ide_err = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        int mis;
        int req0;
        n_checks = 0; n_errs = 0; req_cnt = 0;
        bus.cpu_sel = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_din = 0;
        bus.ide_ack = 0; bus.ide_err = 0; bus.ide_reg_i_adr = 0; bus.ide_reg_we = 0;
        bus.ide_reg_o_adr = 0; bus.ide_reg_o = 0; bus.ide_data_addr = 0;
        bus.ide_data_o = 0; bus.ide_data_rd = 0; bus.ide_data_we = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", 32'(bus.cpu_dout), 32'h0);
        chk("rst_data_i", 32'(bus.ide_data_i), 32'h0);
        chk("rst_irq", 32'(bus.cpu_irq), 32'h0);
        chk("rst_req", 32'(bus.ide_req), 32'h0);
        rst = 1'b0;
        tick();
        cpu_rd(3'd7, 16'h0050, "rst_status");
        hps_reg(3'd2, 8'h00, "rst_count");
        cpu_rd(3'd0, 16'hFFFF, "idle_data_read");

        // Read-type command, one sector
        cpu_wr(3'd2, 16'h0001);
        cpu_wr(3'd3, 16'h0005);
        cpu_wr(3'd7, 16'h0020);
        chk("rd_req_hi", 32'(bus.ide_req), 32'h1);
        tick();
        chk("rd_req_lo", 32'(bus.ide_req), 32'h0);
        hps_reg(3'd3, 8'h05, "hps_sector");
        hps_reg(3'd7, 8'h20, "hps_cmd");
        cpu_rd(3'd7, 16'h0080, "busy_status");
        cpu_wr(3'd5, 16'h00EE);
        hps_reg(3'd5, 8'h00, "busy_reg_wr_ignored");
        for (int i = 0; i < 256; i++) begin
            if (i == 255) chk("irq_before_wrap", 32'(bus.cpu_irq), 32'h0);
            hps_wr(8'(i), 16'(i));
        end
        chk("drq_in_irq", 32'(bus.cpu_irq), 32'h1);
        cpu_rd(3'd7, 16'h0058, "drq_in_status");
        chk("irq_cleared", 32'(bus.cpu_irq), 32'h0);
        mis = n_errs;
        for (int i = 0; i < 256; i++) cpu_rd(3'd0, 16'(i), "sector_in_word");
        chk("sector_in_clean", 32'(n_errs - mis), 32'h0);
        cpu_rd(3'd7, 16'h0050, "after_read_status");
        hps_reg(3'd2, 8'h00, "count_decremented");
        chk("req_total_read", 32'(req_cnt), 32'h1);

        // Write-type command, two sectors
        cpu_wr(3'd2, 16'h0002);
        cpu_wr(3'd7, 16'h0030);
        chk("wr_no_req", 32'(bus.ide_req), 32'h0);
        cpu_rd(3'd7, 16'h0058, "wr_drq_status");
        for (int i = 0; i < 256; i++) cpu_wr(3'd0, 16'hA500 ^ 16'(i * 3));
        chk("wr_req_hi", 32'(bus.ide_req), 32'h1);
        cpu_rd(3'd7, 16'h0080, "wr_busy_status");
        mis = n_errs;
        for (int i = 0; i < 256; i++) hps_rd(8'(i), 16'hA500 ^ 16'(i * 3), "hps_readback");
        chk("hps_readback_clean", 32'(n_errs - mis), 32'h0);
        ack(1'b0);
        chk("wr_ack_irq", 32'(bus.cpu_irq), 32'h1);
        hps_reg(3'd2, 8'h01, "wr_count_dec");
        cpu_rd(3'd7, 16'h0058, "wr_second_drq");
        req0 = req_cnt;
        for (int i = 0; i < 256; i++) cpu_wr(3'd0, 16'h5A00 + 16'(i));
        hps_rd(8'd200, 16'h5AC8, "hps_second_word");
        chk("wr_req_second", 32'(req_cnt - req0), 32'h1);
        ack(1'b0);
        cpu_rd(3'd7, 16'h0050, "wr_done_status");
        hps_reg(3'd2, 8'h01, "wr_last_count");

        // Error completion
        cpu_wr(3'd2, 16'h0001);
        cpu_wr(3'd7, 16'h0021);
        tick();
        ack(1'b1);
        chk("err_irq", 32'(bus.cpu_irq), 32'h1);
        cpu_rd(3'd7, 16'h0051, "err_status");
        chk("err_irq_cleared", 32'(bus.cpu_irq), 32'h0);
        cpu_rd(3'd7, 16'h0051, "err_sticky");

        // HPS write beats a same-cycle CPU write
        bus.ide_reg_we = 1'b1; bus.ide_reg_o_adr = 3'd4; bus.ide_reg_o = 8'h22;
        cpu_wr(3'd4, 16'h0011);
        bus.ide_reg_we = 1'b0;
        hps_reg(3'd4, 8'h22, "hps_wins");
        cpu_rd(3'd4, 16'h0022, "cpu_sees_hps");

        // Reset in the middle of a sector read
        cpu_wr(3'd2, 16'h0001);
        cpu_wr(3'd7, 16'h0020);
        for (int i = 0; i < 256; i++) hps_wr(8'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 10; i++) cpu_rd(3'd0, 16'h1000 + 16'(i), "pre_reset_word");
        req0 = req_cnt;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("mid_reset_req", 32'(req_cnt - req0), 32'h0);
        cpu_rd(3'd7, 16'h0050, "mid_reset_status");
        hps_reg(3'd2, 8'h00, "mid_reset_count");
        cpu_wr(3'd2, 16'h0001);
        cpu_wr(3'd7, 16'h0020);
        for (int i = 0; i < 256; i++) hps_wr(8'(i), 16'h2000 + 16'(i));
        cpu_rd(3'd0, 16'h2000, "restart_word0");
        cpu_rd(3'd0, 16'h2001, "restart_word1");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
